// File: rtl/wb_mem_tester.sv
// Wishbone classic master that fills a word region with a keyed pattern,
// reads it back, and reports the mismatch/err count and first failing address.
module wb_mem_tester #(
  parameter int unsigned ADR_WIDTH = 11,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter logic [31:0] PAT_XOR   = 32'hA5C3_0F96,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [31:0] fail_adr,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_ms,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t               state;
  logic [ADR_WIDTH-1:0] idx;
  logic [ADR_WIDTH-1:0] idx_nxt;
  logic [15:0]          wait_cnt;
  logic                 resp_err;
  logic                 resp_rty;
  logic                 resp_ack;
  logic                 complete;
  logic                 fail;
  logic                 expired;

  function automatic logic [31:0] pattern(input logic [ADR_WIDTH-1:0] i);
    logic [15:0] w;
    w = 16'(i);
    return {w, ~w} ^ PAT_XOR;
  endfunction

  function automatic logic [31:0] adr_of(input logic [ADR_WIDTH-1:0] i);
    return BASE_ADR + 32'({i, 2'b00});
  endfunction

  // Responses only count while stb is up; err outranks rty, rty outranks ack.
  always_comb begin
    resp_err = wb_stb & wb_err;
    resp_rty = wb_stb & ~wb_err & wb_rty;
    resp_ack = wb_stb & ~wb_err & ~wb_rty & wb_ack;
    complete = resp_err | resp_ack;
    fail     = resp_err | (resp_ack & (state == READ) & (wb_dat_sm != pattern(idx)));
    expired  = ~complete & (wait_cnt == 16'(TIMEOUT - 1));
    idx_nxt  = idx + ADR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      fail_adr  <= '0;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      wb_we     <= 1'b0;
      wb_adr    <= '0;
      wb_sel    <= '0;
      wb_dat_ms <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WRITE;
            idx       <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            fail_adr  <= '0;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            wb_we     <= 1'b1;
            wb_adr    <= adr_of('0);
            wb_sel    <= '1;
            wb_dat_ms <= pattern('0);
          end
        end
        WRITE, READ: begin
          if (fail) begin
            if (err_cnt == '0) fail_adr <= wb_adr;
            if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
          end
          if (complete) begin
            wait_cnt  <= '0;
            idx       <= idx_nxt;
            wb_adr    <= adr_of(idx_nxt);
            wb_dat_ms <= pattern(idx_nxt);
            if (&idx) begin
              // Write pass rolls straight into the read pass with stb held high.
              if (state == WRITE) begin
                state <= READ;
                wb_we <= 1'b0;
              end else begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                wb_cyc <= 1'b0;
                wb_stb <= 1'b0;
                wb_we  <= 1'b0;
              end
            end
          end else if (expired) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
          end else begin
            // A retry drops stb for one cycle; the wait counter keeps running.
            wait_cnt <= wait_cnt + 16'd1;
            wb_stb   <= ~resp_rty;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
